inst_queue: RTL and testbench

//  Instruction buffer between fetch and the opcode decoder in the OoO pipe.

---
 rtl/inst_queue_pkg.sv | 27 ++
 rtl/inst_queue.sv | 100 ++++++++++
 tb/tb_inst_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared opcode constants and field helpers for fetch/decode
package inst_queue_pkg;

    localparam int PC_W_DEF   = 32;
    localparam int INST_W_DEF = 32;
    localparam int OPC_W      = 6;

    // Opcode sits in the top OPC_W bits of the instruction word.
    localparam int OPC_LSB_DEF = INST_W_DEF - OPC_W;

    typedef enum logic [OPC_W-1:0] {
        OPC_NOP  = 6'b000000,
        OPC_ADD  = 6'b000001,
        OPC_SUB  = 6'b000010,
        OPC_AND  = 6'b000011,
        OPC_OR   = 6'b000100,
        OPC_LD   = 6'b100000,
        OPC_ST   = 6'b101000,
        OPC_BR   = 6'b110000,
        OPC_HALT = 6'b110001
    } opcode_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_W_DEF-1:0] inst);
        return inst[INST_W_DEF-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction FIFO with flush and sticky HALT fence
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PC_W     = PC_W_DEF,
    parameter int INST_W   = INST_W_DEF,
    parameter int DROP_NOP = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    input  logic [PC_W-1:0]            push_pc,
    input  logic [INST_W-1:0]          push_inst,
    output logic                       full,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       head_valid,
    output logic [PC_W-1:0]            head_pc,
    output logic [INST_W-1:0]          head_inst,
    output logic [OPC_W-1:0]           head_opcode,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PC_W-1:0]   r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_halted;

    logic [OPC_W-1:0]  w_push_opc;
    logic              w_is_nop;
    logic              w_is_halt;
    logic              w_not_full;
    logic              w_not_empty;
    logic              w_push;
    logic              w_pop;

    assign w_push_opc  = push_inst[INST_W-1 -: OPC_W];
    assign w_is_nop    = (DROP_NOP != 0) && (w_push_opc == OPC_NOP);
    assign w_is_halt   = (w_push_opc == OPC_HALT);
    assign w_not_full  = (r_count != FULL_CNT);
    assign w_not_empty = (r_count != '0);

    // flush outranks everything; full is judged on the current count so a
    // simultaneous pop never makes room for a push in the same cycle.
    assign w_push = push_valid & w_not_full & ~r_halted & ~flush & ~w_is_nop;
    assign w_pop  = pop & w_not_empty & ~flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= push_pc;
            r_inst_mem[r_wr_ptr] <= push_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_is_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign full        = ~w_not_full | r_halted;
    assign head_valid  = w_not_empty;
    assign head_pc     = w_not_empty ? r_pc_mem[r_rd_ptr]   : '0;
    assign head_inst   = w_not_empty ? r_inst_mem[r_rd_ptr] : '0;
    assign head_opcode = head_inst[INST_W-1 -: OPC_W];
    assign count       = r_count;
    assign halted      = r_halted;

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue
module tb_inst_queue;

    logic        clk;
    logic        rst_n;
    logic        push_valid;
    logic [31:0] push_pc;
    logic [31:0] push_inst;
    logic        full;
    logic        pop;
    logic        flush;
    logic        head_valid;
    logic [31:0] head_pc;
    logic [31:0] head_inst;
    logic [5:0]  head_opcode;
    logic [3:0]  count;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    inst_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_valid  (push_valid),
        .push_pc     (push_pc),
        .push_inst   (push_inst),
        .full        (full),
        .pop         (pop),
        .flush       (flush),
        .head_valid  (head_valid),
        .head_pc     (head_pc),
        .head_inst   (head_inst),
        .head_opcode (head_opcode),
        .count       (count),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic push1(input logic [31:0] pc, input logic [31:0] inst);
        push_valid = 1'b1;
        push_pc    = pc;
        push_inst  = inst;
        step();
        idle();
    endtask

    initial begin
        rst_n      = 1'b0;
        push_valid = 1'b0;
        push_pc    = '0;
        push_inst  = '0;
        pop        = 1'b0;
        flush      = 1'b0;
        step();
        step();
        check("rst_head_valid", head_valid, 0);
        check("rst_full",       full,       0);
        check("rst_count",      count,      0);
        check("rst_halted",     halted,     0);
        check("rst_head_pc",    head_pc,    0);
        check("rst_head_opc",   head_opcode, 0);
        rst_n = 1'b1;
        step();

        // single push, one-cycle latency to head
        push1(32'h100, 32'h0400_0000);
        check("t1_head_valid", head_valid, 1);
        check("t1_opcode",     head_opcode, 6'b000001);
        check("t1_head_pc",    head_pc, 32'h100);
        check("t1_count",      count, 1);
        pop = 1'b1; step(); idle();
        check("t1_count_pop",  count, 0);

        // fill to 8 with pointers starting at 1, so writes wrap 7->0
        for (int i = 0; i < 8; i++) begin
            push1(32'h200 + 32'(4*i), 32'h0400_0000 | 32'(i));
        end
        check("t2_full",  full, 1);
        check("t2_count", count, 8);
        push1(32'h999, 32'h0800_0000);
        check("t2_ninth_count", count, 8);
        check("t2_head0_pc",    head_pc, 32'h200);

        // full with push+pop: pop acts, push refused
        push_valid = 1'b1; push_pc = 32'h300; push_inst = 32'h0400_0300; pop = 1'b1;
        step(); idle();
        check("t3_full_pp_count", count, 7);
        check("t3_full_pp_full",  full, 0);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("t2_pc%0d", i),   head_pc,   32'h200 + 32'(4*i));
            check($sformatf("t2_inst%0d", i), head_inst, 32'h0400_0000 | 32'(i));
            pop = 1'b1; step(); idle();
        end
        check("t2_drained_count", count, 0);
        check("t2_drained_valid", head_valid, 0);
        check("t2_drained_pc",    head_pc, 0);

        // empty with push+pop: pop ignored, push lands
        push_valid = 1'b1; push_pc = 32'h400; push_inst = 32'h0800_0400; pop = 1'b1;
        step(); idle();
        check("t3_empty_pp_count", count, 1);
        check("t3_empty_pp_pc",    head_pc, 32'h400);
        check("t3_empty_pp_opc",   head_opcode, 6'b000010);
        pop = 1'b1; step(); idle();
        pop = 1'b1; step(); idle();
        check("t3_pop_empty_count", count, 0);

        // NOP dropped
        push1(32'h480, 32'h0000_0000);
        check("t4_nop_count", count, 0);
        check("t4_nop_valid", head_valid, 0);

        // HALT fence
        push1(32'h500, 32'h0400_0000);
        push1(32'h504, 32'hC400_0000);
        check("t5_halted", halted, 1);
        check("t5_full",   full, 1);
        push1(32'h508, 32'h0800_0000);
        check("t5_count",       count, 2);
        check("t5_halted_hold", halted, 1);
        check("t5_head_pc",     head_pc, 32'h500);
        flush = 1'b1; step(); idle();
        check("t5_flush_count",  count, 0);
        check("t5_flush_halted", halted, 0);
        check("t5_flush_full",   full, 0);

        // flush beats simultaneous push and pop
        for (int i = 0; i < 5; i++) begin
            push1(32'h600 + 32'(4*i), 32'h0C00_0000);
        end
        check("t6_count5", count, 5);
        push_valid = 1'b1; push_pc = 32'h700; push_inst = 32'h0400_0000; pop = 1'b1; flush = 1'b1;
        step(); idle();
        check("t6_flush_count", count, 0);
        check("t6_flush_valid", head_valid, 0);
        push1(32'h800, 32'h0400_0000);
        check("t6_after_flush_pc", head_pc, 32'h800);

        // asynchronous reset mid-cycle
        push1(32'h804, 32'hC400_0000);
        push1(32'h808, 32'h0400_0000);
        check("t6_pre_rst_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_arst_count",  count, 0);
        check("t6_arst_valid",  head_valid, 0);
        check("t6_arst_pc",     head_pc, 0);
        check("t6_arst_inst",   head_inst, 0);
        check("t6_arst_halted", halted, 0);
        check("t6_arst_full",   full, 0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_post_rst_count", count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
